pe_dot_sequencer: RTL
=====================

// Module: pe_dot_sequencer
// PURPOSE
//  Sequences one internal pe instance (registered w*x, truncated to DATA_WIDTH) through a dot product.
//  Accepts a job (length, weight/activation base addresses) and issues reads to the weight and activation
//  buffers. Accumulates the pe products and returns the sum over a valid/ready result handshake.
//  Sits between the layer scheduler and the buffer SRAMs.
// PARAMETERS
//  DATA_WIDTH  8   pe operand/product width; pe product truncated to DATA_WIDTH, treated unsigned
//  ACC_WIDTH   24  accumulator/result width
//  ADDR_WIDTH  10  buffer address width
//  LEN_WIDTH   10  job length width
// PORTS
//  clk           in   1           clock
//  rst           in   1           asynchronous, active-high reset
//  start_valid   in   1           job request
//  start_ready   out  1           high only in IDLE
//  start_len     in   LEN_WIDTH   element count N, sampled on accept
//  w_base        in   ADDR_WIDTH  weight base address, sampled on accept
//  x_base        in   ADDR_WIDTH  activation base address, sampled on accept
//  rd_en         out  1           read strobe to both buffers
//  w_addr        out  ADDR_WIDTH  weight read address
//  x_addr        out  ADDR_WIDTH  activation read address
//  w_rdata       in   DATA_WIDTH  weight data, valid 1 cycle after rd_en
//  x_rdata       in   DATA_WIDTH  activation data, valid 1 cycle after rd_en
//  result_valid  out  1           result available
//  result_ready  in   1           consumer accepts result
//  result        out  ACC_WIDTH   dot-product sum
//  busy          out  1           high in any state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; start_ready=1; rd_en=0; w_addr=x_addr=0; result_valid=0; result=0; busy=0.
//   Accumulator, counter and valid tags are cleared.
//  FSM IDLE->FETCH->DRAIN->DONE->IDLE.
//  - IDLE: a job is accepted when start_valid&&start_ready (cycle 0). On accept, len/bases are latched
//    and acc is cleared. N>0 -> FETCH. N=0 -> DONE with result=0; result_valid is high in cycle 1.
//  - FETCH: rd_en=1 for exactly N consecutive cycles (1..N).
//    Element i: w_addr=w_base+i, x_addr=x_base+i, mod 2^ADDR_WIDTH (wraps 2^ADDR_WIDTH-1 -> 0).
//    After the N-th read -> DRAIN.
//  - rdata feeds pe w/x directly. The pe output is valid 2 cycles after its rd_en.
//    A 2-stage valid-tag shift register gates accumulation; the pe output is never added when its tag is 0.
//  - acc += zero-extended pe y, mod 2^ACC_WIDTH.
//  - DRAIN: wait until the last tagged product is accumulated (2 cycles) -> DONE.
//  - DONE: result_valid=1 first in cycle N+3 after accept, and is held stable with result until result_ready.
//    On the handshake -> IDLE; start_ready rises the following cycle (no same-cycle restart).
//  - start_valid while start_ready=0 is ignored; no queuing.
//  - result_ready while result_valid=0 has no effect.
//  - Reset mid-job aborts immediately: no partial result, outputs return to reset values.
// CONFIGURATION
//  PE_SEQ_SAT_EN defined:
//    result = min(acc, 2^DATA_WIDTH-1), upper bits zero.
//    The accumulator itself stays ACC_WIDTH and is saturated only at output.
//  PE_SEQ_SAT_EN undefined: result = acc (wrapping).
// TESTING
//  1. N=4, w=[1,2,3,4], x=[5,6,7,8], bases 0 -> reads at addr 0..3 in cycles 1..4; result=70, valid in cycle 7.
//  2. N=1, w=20, x=20 -> pe product truncated: 400 mod 256 = 144; result=144.
//  3. N=0 -> no rd_en pulses; result=0, result_valid in cycle 1; back to IDLE after handshake.
//  4. w_base=1022, x_base=5, N=4 -> w_addr 1022,1023,0,1; x_addr 5..8; sum correct.
//  5. result_ready held low 5 cycles with start_valid=1 -> result stable, start_ready=0, job not accepted.
//     Release -> IDLE, start_ready=1 next cycle, new job accepted.
//  6. Assert rst during FETCH (N=8, cycle 3) -> all outputs reset immediately, no result_valid.
//     Next job result is correct.
//  7. N=2, w=[16,16], x=[15,15] -> products 240+240: result=480 without PE_SEQ_SAT_EN, 255 with it.

Source files
------------

// File: rtl/pe_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pe_dot_sequencer (with helper pe)
// Brief    : Drives one registered multiplier through a dot product over the
//            weight/activation buffers. Define PE_SEQ_SAT_EN to clamp the
//            returned result to 2^DATA_WIDTH-1.
// Revision : 1.0 - initial release
// ============================================================================

module pe #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] w,
   input  logic [DATA_WIDTH-1:0] x,
   output logic [DATA_WIDTH-1:0] y
);
   // Product is evaluated at operand width, so the upper half is dropped here.
   logic [DATA_WIDTH-1:0] w_prod;

   assign w_prod = w * x;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) y <= '0;
      else     y <= w_prod;
   end
endmodule

module pe_dot_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 24,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic [LEN_WIDTH-1:0]  start_len,
   input  logic [ADDR_WIDTH-1:0] w_base,
   input  logic [ADDR_WIDTH-1:0] x_base,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [ADDR_WIDTH-1:0] x_addr,
   input  logic [DATA_WIDTH-1:0] w_rdata,
   input  logic [DATA_WIDTH-1:0] x_rdata,
   output logic                  result_valid,
   input  logic                  result_ready,
   output logic [ACC_WIDTH-1:0]  result,
   output logic                  busy
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                r_state;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [LEN_WIDTH-1:0]  r_cnt;
   logic [ACC_WIDTH-1:0]  r_acc;
   logic [1:0]            r_tag;
   logic [DATA_WIDTH-1:0] w_y;
   logic [ACC_WIDTH-1:0]  w_acc_add;
   logic [ACC_WIDTH-1:0]  w_acc_next;
   logic [ACC_WIDTH-1:0]  w_result_next;

   pe #(.DATA_WIDTH(DATA_WIDTH)) u_pe (
      .clk (clk),
      .rst (rst),
      .w   (w_rdata),
      .x   (x_rdata),
      .y   (w_y)
   );

   assign w_acc_add  = r_acc + ACC_WIDTH'(w_y);
   assign w_acc_next = r_tag[1] ? w_acc_add : r_acc;

`ifdef PE_SEQ_SAT_EN
   localparam logic [ACC_WIDTH-1:0] c_sat_max = ACC_WIDTH'((1 << DATA_WIDTH) - 1);
   assign w_result_next = (w_acc_next > c_sat_max) ? c_sat_max : w_acc_next;
`else
   assign w_result_next = w_acc_next;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_len        <= '0;
         r_cnt        <= '0;
         r_acc        <= '0;
         r_tag        <= '0;
         start_ready  <= 1'b1;
         rd_en        <= 1'b0;
         w_addr       <= '0;
         x_addr       <= '0;
         result_valid <= 1'b0;
         result       <= '0;
         busy         <= 1'b0;
      end else begin
         // tag[0] lines up with buffer data, tag[1] with the pe product
         r_tag <= {r_tag[0], rd_en};
         if (r_tag[1]) r_acc <= w_acc_add;

         case (r_state)
            S_IDLE: begin
               if (start_valid && start_ready) begin
                  start_ready <= 1'b0;
                  busy        <= 1'b1;
                  r_len       <= start_len;
                  r_cnt       <= '0;
                  r_acc       <= '0;
                  w_addr      <= w_base;
                  x_addr      <= x_base;
                  if (start_len == '0) begin
                     result       <= '0;
                     result_valid <= 1'b1;
                     r_state      <= S_DONE;
                  end else begin
                     rd_en   <= 1'b1;
                     r_state <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               r_cnt  <= r_cnt + LEN_WIDTH'(1);
               w_addr <= w_addr + ADDR_WIDTH'(1);
               x_addr <= x_addr + ADDR_WIDTH'(1);
               if (r_cnt == r_len - LEN_WIDTH'(1)) begin
                  rd_en   <= 1'b0;
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Last product is on the pe output when only tag[1] is set.
               if (r_tag[1] && !r_tag[0]) begin
                  result       <= w_result_next;
                  result_valid <= 1'b1;
                  r_state      <= S_DONE;
               end
            end
            S_DONE: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  busy         <= 1'b0;
                  start_ready  <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire
